msi_bus_ctrl: RTL and testbench
===============================

MSI_BUS_CTRL -- requirements
Module: msi_bus_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 2: memory read latency in cycles, legal range 1..15.
REQ-002 Parameter SNOOP_TO, default 15: snoop/flush timeout in cycles, legal range 1..255; used only under REQ-030.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-core bus request; bit0 = CORE0, bit1 = CORE1; held high until done.
REQ-006 cmd0, cmd1  input  2 each  per-core bus command: 00 none, 01 BusRd, 10 BusRdX, 11 BusUpgr.
REQ-007 addr0, addr1  input  8 each  per-core line address.
REQ-008 gnt  output  2  one-hot grant; held for the whole transaction.
REQ-009 bus_valid, bus_cmd[1:0], bus_addr[7:0], bus_src  output  broadcast strobe, latched command, latched address and granted core index.
REQ-010 snoop_ack, snoop_hit_m  input  1 each  non-granted core has finished its snoop; snoop_hit_m means it held the line Modified and will flush.
REQ-011 flush_valid  input  1  flush data from the snooper is on the data bus.
REQ-012 mem_rd, mem_wr  output  1 each  one-cycle memory read and writeback strobes.
REQ-013 done  output  2  one-hot, one-cycle completion pulse to the granted core.
REQ-014 err  output  1  one-cycle timeout pulse, coincident with done.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT, SNOOP, FLUSH, MEM and DONE.
REQ-016 IDLE: when req is nonzero, select one core by round-robin and go to GRANT; otherwise stay in IDLE.
REQ-017 Round-robin SHALL favour the core not served last; after reset CORE0 is favoured; a single requester is always served.
REQ-018 GRANT (one cycle): assert gnt; latch cmd/addr of the winner into bus_cmd/bus_addr/bus_src; pulse bus_valid; go to SNOOP.
REQ-019 If the latched cmd is 00, GRANT SHALL suppress bus_valid and go directly to DONE.
REQ-020 SNOOP: wait for snoop_ack. On ack with snoop_hit_m=1, go to FLUSH. On ack with BusUpgr and snoop_hit_m=0, go to DONE. Otherwise go to MEM.
REQ-021 FLUSH: wait for flush_valid. Pulse mem_wr in the flush_valid cycle, then go to DONE. No mem_rd is issued in this path.
REQ-022 MEM: stay exactly MEM_LAT cycles; pulse mem_rd in the first cycle; then go to DONE.
REQ-023 DONE (one cycle): pulse the done bit of the granted core; update the round-robin pointer; deassert gnt at the next edge; return to IDLE.
REQ-024 bus_cmd, bus_addr and bus_src SHALL hold their latched values from GRANT through DONE.
REQ-025 Latency from req sampled in IDLE (cycle 0): gnt and bus_valid at cycle 1; SNOOP from cycle 2; done is the cycle after the last MEM or FLUSH cycle.
REQ-026 Changes on req, cmd or addr after GRANT SHALL be ignored until IDLE; a transaction always completes.
REQ-027 snoop_ack and flush_valid outside SNOOP or FLUSH SHALL be ignored.

Reset
REQ-028 Reset SHALL force state IDLE, the round-robin pointer to favour CORE0, and the MEM counter and timeout counter to 0.
REQ-029 During reset all outputs SHALL be 0; reset asserted mid-transaction SHALL abort it with no done pulse.

Configuration
REQ-030 With macro MSI_BUS_TIMEOUT_EN defined: a counter runs in SNOOP and FLUSH. If the awaited input is not seen within SNOOP_TO cycles, go to DONE with err pulsed and no mem_rd or mem_wr.
REQ-031 Without MSI_BUS_TIMEOUT_EN: err SHALL be tied 0, SNOOP and FLUSH wait indefinitely, and no counter logic is present.

Structure
REQ-032 Package msi_bus_pkg SHALL hold the command encodings, the FSM state enum, the address width (8) and the core count (2).
REQ-033 Round-robin selection SHALL be the sub-module msi_rr_arb (inputs req and pointer; output one-hot winner).

Verification
REQ-034 CORE0 BusRd 0x10, snoop_ack at cycle 2, snoop_hit_m=0, MEM_LAT=2 -> gnt=01 and bus_valid at cycle 1, mem_rd at cycle 3, done=01 at cycle 5.
REQ-035 CORE1 BusRdX 0x20, ack with snoop_hit_m=1, flush_valid at cycle 4 -> mem_wr at cycle 4, done=10 at cycle 5, no mem_rd.
REQ-036 req=11 held for two back-to-back transactions after reset -> CORE0 served first, then CORE1.
REQ-037 CORE0 BusUpgr 0x10, ack with snoop_hit_m=0 at cycle 2 -> done=01 at cycle 3; no memory strobes.
REQ-038 MSI_BUS_TIMEOUT_EN, SNOOP_TO=4, no snoop_ack -> err and done pulse together at cycle 6; FSM back in IDLE.
REQ-039 Reset asserted in MEM -> all outputs 0 immediately, no done pulse; next request is granted to CORE0 when both request.

Source files
------------

// File: rtl/msi_bus_pkg.sv
// Shared types for the two-core MSI snooping bus controller.
// Command encodings, FSM states and bus geometry.
package msi_bus_pkg;

  localparam int ADDR_W = 8;
  localparam int NCORE  = 2;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_RD   = 2'b01,
    CMD_RDX  = 2'b10,
    CMD_UPGR = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SNOOP,
    S_FLUSH,
    S_MEM,
    S_DONE
  } state_e;

endpackage

// File: rtl/msi_rr_arb.sv
// Two-way round-robin arbiter for the MSI bus.
// ptr names the favoured core; a lone requester always wins.
module msi_rr_arb
  import msi_bus_pkg::*;
(
  input  logic [NCORE-1:0] req,
  input  logic             ptr,
  output logic [NCORE-1:0] win
);

  always_comb begin
    win = '0;
    priority case (1'b1)
      req[ptr]:  win[ptr]  = 1'b1;
      req[!ptr]: win[!ptr] = 1'b1;
      default:   win       = '0;
    endcase
  end

endmodule

// File: rtl/msi_bus_ctrl.sv
// MSI snooping bus controller: arbitration, snoop, flush, memory read.
// Optional snoop/flush timeout enabled by MSI_BUS_TIMEOUT_EN.
module msi_bus_ctrl
  import msi_bus_pkg::*;
#(
  parameter int MEM_LAT  = 2,
  parameter int SNOOP_TO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCORE-1:0]  req,
  input  logic [1:0]        cmd0,
  input  logic [1:0]        cmd1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [NCORE-1:0]  gnt,
  output logic              bus_valid,
  output logic [1:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_src,
  input  logic              snoop_ack,
  input  logic              snoop_hit_m,
  input  logic              flush_valid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [NCORE-1:0]  done,
  output logic              err
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  state_e            state;
  logic              ptr;
  logic [3:0]        mem_cnt;
  logic [NCORE-1:0]  win;
  logic [1:0]        sel_cmd;
  logic [ADDR_W-1:0] sel_addr;

  msi_rr_arb u_arb (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  assign sel_cmd  = win[1] ? cmd1 : cmd0;
  assign sel_addr = win[1] ? addr1 : addr0;

  // Writeback strobe follows the flush data beat directly.
  assign mem_wr = (state == S_FLUSH) && flush_valid;

`ifdef MSI_BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(SNOOP_TO - 1);
  logic [7:0] tmo_cnt;
`else
  assign err = (SNOOP_TO == 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= 1'b0;
      mem_cnt   <= '0;
      gnt       <= '0;
      bus_valid <= 1'b0;
      bus_cmd   <= '0;
      bus_addr  <= '0;
      bus_src   <= 1'b0;
      mem_rd    <= 1'b0;
      done      <= '0;
`ifdef MSI_BUS_TIMEOUT_EN
      tmo_cnt   <= '0;
      err       <= 1'b0;
`endif
    end else begin
      bus_valid <= 1'b0;
      mem_rd    <= 1'b0;
      done      <= '0;
`ifdef MSI_BUS_TIMEOUT_EN
      err       <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            state     <= S_GRANT;
            gnt       <= win;
            bus_src   <= win[1];
            bus_cmd   <= sel_cmd;
            bus_addr  <= sel_addr;
            bus_valid <= (sel_cmd != CMD_NONE);
          end
        end
        S_GRANT: begin
`ifdef MSI_BUS_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (bus_cmd == CMD_NONE) begin
            state <= S_DONE;
            done  <= gnt;
          end else begin
            state <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          if (snoop_ack) begin
`ifdef MSI_BUS_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (snoop_hit_m) begin
              state <= S_FLUSH;
            end else if (bus_cmd == CMD_UPGR) begin
              state <= S_DONE;
              done  <= gnt;
            end else begin
              state   <= S_MEM;
              mem_rd  <= 1'b1;
              mem_cnt <= '0;
            end
          end
`ifdef MSI_BUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state <= S_DONE;
            done  <= gnt;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        S_FLUSH: begin
          if (flush_valid) begin
            state <= S_DONE;
            done  <= gnt;
          end
`ifdef MSI_BUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state <= S_DONE;
            done  <= gnt;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        S_MEM: begin
          if (mem_cnt == MEM_LAST) begin
            state <= S_DONE;
            done  <= gnt;
          end else begin
            mem_cnt <= mem_cnt + 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= '0;
          ptr   <= ~bus_src;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msi_bus_ctrl.sv
// Scoreboard bench for msi_bus_ctrl: timing model pushes expectations,
// a negedge monitor pops one per done pulse and compares.
module tb_msi_bus_ctrl;

  localparam int MEM_LAT  = 2;
  localparam int SNOOP_TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, cmd0, cmd1;
  logic [7:0] addr0, addr1;
  logic [1:0] gnt, bus_cmd, done;
  logic       bus_valid, bus_src;
  logic [7:0] bus_addr;
  logic       snoop_ack, snoop_hit_m, flush_valid;
  logic       mem_rd, mem_wr, err;

  msi_bus_ctrl #(.MEM_LAT(MEM_LAT), .SNOOP_TO(SNOOP_TO)) dut (
    .clk(clk), .reset(rst), .req(req),
    .cmd0(cmd0), .cmd1(cmd1), .addr0(addr0), .addr1(addr1),
    .gnt(gnt), .bus_valid(bus_valid), .bus_cmd(bus_cmd),
    .bus_addr(bus_addr), .bus_src(bus_src),
    .snoop_ack(snoop_ack), .snoop_hit_m(snoop_hit_m),
    .flush_valid(flush_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int src; int cmd; int addr; int done_cyc;
    int bv_cyc; int rd_cyc; int wr_cyc; int err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
  bit ptr_m = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int outs();
    return int'({gnt, bus_valid, bus_cmd, bus_addr, bus_src,
                 mem_rd, mem_wr, done, err});
  endfunction

  // monitor accumulators for the transaction in flight
  int bv_n, bv_c, rd_n, rd_c, wr_n, wr_c, err_n;

  task automatic clr();
    bv_n = 0; bv_c = -1; rd_n = 0; rd_c = -1;
    wr_n = 0; wr_c = -1; err_n = 0;
  endtask

  initial clr();

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", outs(), 0);
      clr();
    end else begin
      if (bus_valid) begin bv_n++; bv_c = cyc; end
      if (mem_rd) begin rd_n++; rd_c = cyc; end
      if (mem_wr) begin wr_n++; wr_c = cyc; end
      err_n += int'(err);
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("stray_done", int'(done), 0);
        end else begin
          e = sb.pop_front();
          chk("done_vec", int'(done), 1 << e.src);
          chk("done_cycle", cyc, e.done_cyc);
          chk("gnt", int'(gnt), 1 << e.src);
          chk("bus_src", int'(bus_src), e.src);
          chk("bus_cmd", int'(bus_cmd), e.cmd);
          chk("bus_addr", int'(bus_addr), e.addr);
          chk("bus_valid_n", bv_n, (e.bv_cyc >= 0) ? 1 : 0);
          chk("bus_valid_cyc", bv_c, e.bv_cyc);
          chk("mem_rd_n", rd_n, (e.rd_cyc >= 0) ? 1 : 0);
          chk("mem_rd_cyc", rd_c, e.rd_cyc);
          chk("mem_wr_n", wr_n, (e.wr_cyc >= 0) ? 1 : 0);
          chk("mem_wr_cyc", wr_c, e.wr_cyc);
          chk("err_n", err_n, e.err);
        end
        clr();
      end
    end
  end

  task automatic run_txn(input logic [1:0] r,
                         input logic [1:0] c0, input logic [1:0] c1,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input int d, input int f,
                         input bit hit, input bit no_ack);
    int st, w, cmd, ack_rel, fl_rel, done_rel;
    bit in_snp, in_fl;
    exp_t x;
    @(posedge clk); #1;
    st = cyc;
    req = r; cmd0 = c0; cmd1 = c1; addr0 = a0; addr1 = a1;
    snoop_ack = 1'($urandom); flush_valid = 1'($urandom);
    snoop_hit_m = 1'($urandom);
    w = r[ptr_m] ? int'(ptr_m) : int'(!ptr_m);
    cmd = (w == 1) ? int'(c1) : int'(c0);
    ack_rel = 2 + d;
    fl_rel = 3 + d + f;
    x.src = w; x.cmd = cmd;
    x.addr = (w == 1) ? int'(a1) : int'(a0);
    x.bv_cyc = (cmd != 0) ? st + 1 : -1;
    x.rd_cyc = -1; x.wr_cyc = -1; x.err = 0;
    if (cmd == 0) begin
      done_rel = 2;
    end else if (no_ack) begin
      done_rel = 2 + SNOOP_TO;
      x.err = 1;
    end else if (hit) begin
      done_rel = fl_rel + 1;
      x.wr_cyc = st + fl_rel;
    end else if (cmd == 3) begin
      done_rel = ack_rel + 1;
    end else begin
      done_rel = ack_rel + 1 + MEM_LAT;
      x.rd_cyc = st + ack_rel + 1;
    end
    x.done_cyc = st + done_rel;
    sb.push_back(x);
    ptr_m = (w == 0);
    for (int rel = 1; rel <= done_rel; rel++) begin
      @(posedge clk); #1;
      cmd0 = 2'($urandom); cmd1 = 2'($urandom);
      addr0 = 8'($urandom); addr1 = 8'($urandom);
      in_snp = (cmd != 0) && rel >= 2 &&
               rel < (no_ack ? done_rel : ack_rel + 1);
      in_fl = (cmd != 0) && !no_ack && hit &&
              rel > ack_rel && rel <= fl_rel;
      snoop_hit_m = 1'($urandom);
      if (in_snp) begin
        snoop_ack = (!no_ack && rel == ack_rel);
        if (snoop_ack) snoop_hit_m = hit;
      end else begin
        snoop_ack = 1'($urandom);
      end
      flush_valid = in_fl ? (rel == fl_rel) : 1'($urandom);
      if (rel == done_rel) req = 2'b00;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; cmd0 = '0; cmd1 = '0;
    addr0 = '0; addr1 = '0;
    snoop_ack = 1'b0; snoop_hit_m = 1'b0; flush_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // both cores requesting: CORE0 first, then CORE1
    run_txn(2'b11, 2'd1, 2'd2, 8'h11, 8'h22, 0, 0, 1'b0, 1'b0);
    run_txn(2'b11, 2'd1, 2'd2, 8'h11, 8'h22, 1, 0, 1'b0, 1'b0);
    // CORE0 BusRd, clean snoop
    run_txn(2'b01, 2'd1, 2'd0, 8'h10, 8'h00, 0, 0, 1'b0, 1'b0);

    // abort in MEM with CORE1 favoured
    @(posedge clk); #1;
    req = 2'b11; cmd0 = 2'd1; cmd1 = 2'd1;
    addr0 = 8'h33; addr1 = 8'h44;
    @(posedge clk); #1;
    @(posedge clk); #1;
    snoop_ack = 1'b1; snoop_hit_m = 1'b0;
    @(posedge clk); #1;
    snoop_ack = 1'b0;
    rst = 1'b1;
    #1 chk("abort_zero", outs(), 0);
    req = 2'b00;
    ptr_m = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    run_txn(2'b11, 2'd1, 2'd1, 8'h55, 8'h66, 0, 0, 1'b0, 1'b0);

    // CORE1 BusRdX with Modified hit and flush
    run_txn(2'b10, 2'd0, 2'd2, 8'h00, 8'h20, 0, 1, 1'b1, 1'b0);
    // CORE0 BusUpgr, no hit
    run_txn(2'b01, 2'd3, 2'd0, 8'h10, 8'h00, 0, 0, 1'b0, 1'b0);
    // null command skips the snoop
    run_txn(2'b10, 2'd1, 2'd0, 8'h01, 8'h02, 0, 0, 1'b0, 1'b0);
`ifdef MSI_BUS_TIMEOUT_EN
    run_txn(2'b01, 2'd1, 2'd0, 8'h10, 8'h00, 0, 0, 1'b0, 1'b1);
    run_txn(2'b01, 2'd1, 2'd0, 8'h12, 8'h00, 0, 0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      run_txn(2'($urandom_range(1, 3)),
              2'($urandom), 2'($urandom),
              8'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
